bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit multiplexed 7-segment display driver; its D0..D3 outputs connect straight to that driver's D0..D3 (units..thousands).
- Outputs hold the last committed result while a new conversion runs, so the display never shows intermediate values.

---
 rtl/display_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display-path types and constants (converter and 7-segment driver).
package display_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_t;

   localparam int BCD_DIGITS        = 4;
   localparam int BCD_WIDTH         = 4 * BCD_DIGITS;
   localparam int MAX_DISPLAY_VALUE = 9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// Purely combinational; no state, no flow control.
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Serial binary-to-BCD converter, one bit per clock; DONE pulses IN_WIDTH cycles after START.
// START is ignored while BUSY; outputs hold the last committed result between commits.
module bin_to_bcd_seq
   import display_pkg::*;
#(
   parameter int IN_WIDTH  = 14,
   parameter int MAX_VALUE = MAX_DISPLAY_VALUE
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic [IN_WIDTH-1:0] BIN,
   output logic                BUSY,
   output logic                DONE,
   output logic                OVERFLOW,
   output logic [3:0]          D0,
   output logic [3:0]          D1,
   output logic [3:0]          D2,
   output logic [3:0]          D3
);

   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

   conv_state_t          state_q, state_d;
   logic [IN_WIDTH-1:0]  shift_q, shift_d;
   logic [BCD_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_pend_q, ovf_pend_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic [BCD_WIDTH-1:0] digits_q, digits_d;

   logic [BCD_WIDTH-1:0] acc_adj;
   logic [BCD_WIDTH-1:0] acc_iter;
   logic [IN_WIDTH-1:0]  shift_iter;
   logic                 in_over;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (acc_q[4*g +: 4]),
         .dout (acc_adj[4*g +: 4])
      );
   end

   // Carry out of the top digit is dropped; only saturating inputs can produce it.
   assign acc_iter   = BCD_WIDTH'({acc_adj, shift_q[IN_WIDTH-1]});
   assign shift_iter = {shift_q[IN_WIDTH-2:0], 1'b0};
   assign in_over    = (32'(BIN) > $unsigned(MAX_VALUE));

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      digits_d   = digits_q;

      case (state_q)
         IDLE: begin
            if (START) begin
               shift_d    = BIN;
               acc_d      = '0;
               ovf_pend_d = in_over;
               cnt_d      = '0;
               state_d    = CONV;
            end
         end
         CONV: begin
            acc_d   = acc_iter;
            shift_d = shift_iter;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (ovf_pend_q) begin
                  digits_d = {BCD_DIGITS{4'd9}};
                  ovf_d    = 1'b1;
               end else begin
                  digits_d = acc_iter;
                  ovf_d    = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         digits_q   <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         digits_q   <= digits_d;
      end
   end

   assign BUSY     = (state_q == CONV);
   assign DONE     = done_q;
   assign OVERFLOW = ovf_q;
   assign D0       = digits_q[3:0];
   assign D1       = digits_q[7:4];
   assign D2       = digits_q[11:8];
   assign D3       = digits_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq at default parameters.
module tb_bin_to_bcd_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [13:0] BIN = '0;
   logic        BUSY, DONE, OVERFLOW;
   logic [3:0]  D0, D1, D2, D3;

   int vectors = 0;
   int miscompares = 0;
   int done_count = 0;
   logic [16:0] exp_q[$];

   bin_to_bcd_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .BIN(BIN),
      .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {D3,D2,D1,D0,OVERFLOW} expected for an input value
   function automatic logic [16:0] expect_of(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10), 1'(v > 9999)};
   endfunction

   always @(negedge CLK) begin : monitor
      logic [16:0] e;
      logic [16:0] got;
      if (DONE === 1'b1) begin
         done_count++;
         vectors++;
         if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_with_done: BUSY=%b required 0", BUSY);
         end
         got = {D3, D2, D1, D0, OVERFLOW};
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got %h, no result expected", got);
         end else begin
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL result: digits/ovf got %h required %h", got, e);
            end
         end
      end
   end

   // Starts a conversion at the next edge and waits for DONE; ends on the DONE negedge.
   task automatic run_conv(input int v, input bit push, output int lat,
                           output int busy_n, output int hold_bad);
      logic [16:0] hold;
      hold = {D3, D2, D1, D0, OVERFLOW};
      START = 1'b1;
      BIN = 14'(v);
      if (push) exp_q.push_back(expect_of(v));
      @(posedge CLK); #1;
      START = 1'b0;
      BIN = 14'($urandom);
      lat = -1; busy_n = 0; hold_bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (BUSY === 1'b1) begin
            busy_n++;
            if ({D3, D2, D1, D0, OVERFLOW} !== hold) hold_bad++;
         end
         if (DONE === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; BIN = '0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", BUSY); end
      vectors++;
      if (DONE !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", DONE); end
      vectors++;
      if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b required 0", OVERFLOW); end
      vectors++;
      if ({D3, D2, D1, D0} !== 16'h0000) begin
         miscompares++; $display("FAIL reset_digits: got %h required 0000", {D3, D2, D1, D0});
      end
   endtask

   task automatic test_zero();
      int lat, bn, hb;
      run_conv(0, 1'b1, lat, bn, hb);
      vectors++;
      if (lat !== 14) begin miscompares++; $display("FAIL zero_latency: got %0d required 14", lat); end
      vectors++;
      if (bn !== 14) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d required 14", bn); end
   endtask

   task automatic test_hold_1234();
      int lat, bn, hb;
      run_conv(1234, 1'b1, lat, bn, hb);
      vectors++;
      if (hb !== 0) begin miscompares++; $display("FAIL hold_during_conv: %0d changed cycles, required 0", hb); end
      vectors++;
      if (lat !== 14) begin miscompares++; $display("FAIL latency_1234: got %0d required 14", lat); end
   endtask

   task automatic test_saturate();
      int vals[3] = '{9999, 10000, 16383};
      int lat, bn, hb;
      foreach (vals[i]) begin
         run_conv(vals[i], 1'b1, lat, bn, hb);
         vectors++;
         if (lat !== 14) begin
            miscompares++; $display("FAIL latency_%0d: got %0d required 14", vals[i], lat);
         end
      end
      repeat (5) @(negedge CLK);
      vectors++;
      if ({D3, D2, D1, D0, OVERFLOW} !== {16'h9999, 1'b1}) begin
         miscompares++; $display("FAIL sat_hold: got %h required %h", {D3, D2, D1, D0, OVERFLOW}, {16'h9999, 1'b1});
      end
   endtask

   task automatic test_ignore_start();
      int dc;
      dc = done_count;
      START = 1'b1; BIN = 14'd42;
      exp_q.push_back(expect_of(42));
      @(posedge CLK); #1 START = 1'b0;
      repeat (5) @(posedge CLK);
      #1 START = 1'b1; BIN = 14'd7777;
      @(posedge CLK); #1 START = 1'b0;
      for (int c = 0; c < 40 && done_count == dc; c++) @(negedge CLK);
      repeat (20) @(negedge CLK);
      vectors++;
      if (done_count - dc !== 1) begin
         miscompares++; $display("FAIL ignore_start_pulses: got %0d DONE pulses required 1", done_count - dc);
      end
   endtask

   task automatic test_back_to_back();
      int first, second;
      first = -1; second = -1;
      START = 1'b1; BIN = 14'd5;
      exp_q.push_back(expect_of(5));
      exp_q.push_back(expect_of(10));
      @(posedge CLK); #1 BIN = 14'd10;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            if (first < 0) first = c;
            else begin
               second = c;
               START = 1'b0;
               break;
            end
         end
         @(posedge CLK); #1;
      end
      START = 1'b0;
      vectors++;
      if (first !== 14) begin miscompares++; $display("FAIL b2b_first_latency: got %0d required 14", first); end
      vectors++;
      if (second - first !== 15) begin
         miscompares++; $display("FAIL b2b_spacing: got %0d required 15", second - first);
      end
   endtask

   task automatic test_reset_abort();
      int lat, bn, hb, dc;
      run_conv(321, 1'b1, lat, bn, hb);
      START = 1'b1; BIN = 14'd8888;
      @(posedge CLK); #1 START = 1'b0;
      repeat (6) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      dc = done_count;
      @(negedge CLK);
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b required 0", BUSY); end
      vectors++;
      if ({D3, D2, D1, D0, OVERFLOW} !== 17'h0) begin
         miscompares++; $display("FAIL abort_digits: got %h required 00000", {D3, D2, D1, D0, OVERFLOW});
      end
      repeat (20) @(negedge CLK);
      vectors++;
      if (done_count !== dc) begin
         miscompares++; $display("FAIL abort_no_done: got %0d DONE pulses required 0", done_count - dc);
      end
      run_conv(8888, 1'b1, lat, bn, hb);
      vectors++;
      if (lat !== 14) begin miscompares++; $display("FAIL latency_8888: got %0d required 14", lat); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_hold_1234();
      test_saturate();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      repeat (5) @(negedge CLK);
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
